// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, the x0 address and the registered write-stage payload used by the
// writeback arbiter and its scoreboard.
package regfile_wb_arbiter_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned NREG         = 32;
    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned DEF_MAX_WAIT = 4;

    localparam logic [REG_ADDR_W-1:0] X0_ADDR = '0;

    // One register-file write as it leaves the arbiter; src_lsu marks load returns.
    typedef struct packed {
        logic                  en;
        logic                  src_lsu;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       value;
    } wb_wr_t;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// wb_scoreboard: one busy bit per architectural register for loads in flight,
// with two decode read ports and the load-issue check port. Bit 0 never sets.
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [REG_ADDR_W-1:0] issue_addr,
    output logic                  rs1_busy_c,
    output logic                  rs2_busy_c,
    output logic                  issue_busy_c
);

    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;

    // Clear first so that a same-cycle set of the same register wins.
    always_comb begin
        sb_d = sb_q;
        if (clr_en) begin
            sb_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            sb_d[set_addr] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign rs1_busy_c   = sb_q[rs1_addr];
    assign rs2_busy_c   = sb_q[rs2_addr];
    assign issue_busy_c = sb_q[issue_addr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline WB and the LSU,
// tracks in-flight loads for RAW stalls. Optional bypass: REGFILE_ARB_BYPASS_EN.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_valid,
    output logic                  pipe_ready,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    input  logic                  ld_issue_valid,
    output logic                  ld_issue_ready,
    input  logic [REG_ADDR_W-1:0] ld_issue_rd,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rf_write_en,
    output logic [REG_ADDR_W-1:0] rf_write_addr,
    output logic [XLEN-1:0]       rf_write_value,
    output logic                  rs1_fwd_valid,
    output logic [XLEN-1:0]       rs1_fwd_data,
    output logic                  rs2_fwd_valid,
    output logic [XLEN-1:0]       rs2_fwd_data
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 2);

    logic             grant_pipe;
    logic             grant_lsu;
    logic [CNT_W-1:0] wait_q;
    logic [CNT_W-1:0] wait_d;
    wb_wr_t           wr_q;
    wb_wr_t           wr_d;
    logic             sb_rs1;
    logic             sb_rs2;
    logic             sb_issue;

    // Pipeline wins unless it is idle or the LSU has lost MAX_WAIT cycles in a row.
    always_comb begin
        grant_lsu  = lsu_valid && (!pipe_valid || (wait_q >= CNT_W'(MAX_WAIT)));
        grant_pipe = pipe_valid && !grant_lsu;

        wait_d = '0;
        if (lsu_valid && !grant_lsu) begin
            wait_d = (wait_q >= CNT_W'(MAX_WAIT)) ? wait_q : wait_q + CNT_W'(1);
        end

        wr_d         = wr_q;
        wr_d.en      = 1'b0;
        wr_d.src_lsu = 1'b0;
        if (grant_lsu) begin
            wr_d.en      = (lsu_rd != X0_ADDR);
            wr_d.src_lsu = 1'b1;
            wr_d.addr    = lsu_rd;
            wr_d.value   = lsu_data;
        end else if (grant_pipe) begin
            wr_d.en    = (pipe_rd != X0_ADDR);
            wr_d.addr  = pipe_rd;
            wr_d.value = pipe_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= '0;
            wr_q   <= '0;
        end else begin
            wait_q <= wait_d;
            wr_q   <= wr_d;
        end
    end

    // Busy bit drops at the same edge the register file commits the load data.
    wb_scoreboard u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .set_en       (ld_issue_valid && ld_issue_ready),
        .set_addr     (ld_issue_rd),
        .clr_en       (wr_q.en && wr_q.src_lsu),
        .clr_addr     (wr_q.addr),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .issue_addr   (ld_issue_rd),
        .rs1_busy_c   (sb_rs1),
        .rs2_busy_c   (sb_rs2),
        .issue_busy_c (sb_issue)
    );

    assign pipe_ready     = pipe_valid ? grant_pipe : 1'b1;
    assign lsu_ready      = grant_lsu;
    assign ld_issue_ready = !sb_issue || (ld_issue_rd == X0_ADDR);

    assign rf_write_en    = wr_q.en;
    assign rf_write_addr  = wr_q.addr;
    assign rf_write_value = wr_q.value;

`ifdef REGFILE_ARB_BYPASS_EN
    assign rs1_fwd_valid = wr_q.en && (wr_q.addr == rs1_addr) && (rs1_addr != X0_ADDR);
    assign rs2_fwd_valid = wr_q.en && (wr_q.addr == rs2_addr) && (rs2_addr != X0_ADDR);
    assign rs1_fwd_data  = wr_q.value;
    assign rs2_fwd_data  = wr_q.value;
    assign rs1_busy      = sb_rs1 && !rs1_fwd_valid;
    assign rs2_busy      = sb_rs2 && !rs2_fwd_valid;
`else
    assign rs1_fwd_valid = 1'b0;
    assign rs2_fwd_valid = 1'b0;
    assign rs1_fwd_data  = '0;
    assign rs2_fwd_data  = '0;
    assign rs1_busy      = sb_rs1;
    assign rs2_busy      = sb_rs2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random traffic,
// all compared every cycle against a behavioural model of the writeback rules.
module tb_regfile_wb_arbiter;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_valid, pipe_ready, lsu_valid, lsu_ready;
    logic [4:0]  pipe_rd, lsu_rd, ld_issue_rd, rs1_addr, rs2_addr, rf_write_addr;
    logic [31:0] pipe_data, lsu_data, rf_write_value, rs1_fwd_data, rs2_fwd_data;
    logic        ld_issue_valid, ld_issue_ready, rs1_busy, rs2_busy, rf_write_en;
    logic        rs1_fwd_valid, rs2_fwd_valid;

    int errors = 0;
    int checks = 0;

    // Model state: per-register pending-load flags, consecutive LSU losses,
    // and the write currently presented to the register file.
    bit [31:0] m_sb;
    int        m_wait;
    bit        m_en, m_src_lsu;
    bit [4:0]  m_addr;
    bit [31:0] m_val;
    bit        last_gp, last_gl;
    bit        bypass;

    regfile_wb_arbiter #(.MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready), .ld_issue_rd(ld_issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_value(rf_write_value),
        .rs1_fwd_valid(rs1_fwd_valid), .rs1_fwd_data(rs1_fwd_data),
        .rs2_fwd_valid(rs2_fwd_valid), .rs2_fwd_data(rs2_fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sb = '0; m_wait = 0; m_en = 0; m_src_lsu = 0; m_addr = '0; m_val = '0;
        last_gp = 0; last_gl = 0;
    endtask

    // One clock cycle: compare at the falling edge, advance the model past the rising edge.
    task automatic step();
        bit gl, gp, ir, f1, f2;
        int nw;
        bit [31:0] nsb;
        @(negedge clk);
        gl = lsu_valid && (!pipe_valid || m_wait >= MW);
        gp = pipe_valid && !gl;
        ir = (ld_issue_rd == 0) || !m_sb[ld_issue_rd];
        f1 = bypass && m_en && (m_addr == rs1_addr) && (rs1_addr != 0);
        f2 = bypass && m_en && (m_addr == rs2_addr) && (rs2_addr != 0);
        chk("pipe_ready", pipe_ready, !pipe_valid || gp);
        chk("lsu_ready", lsu_ready, gl);
        chk("ld_issue_ready", ld_issue_ready, ir);
        chk("rs1_busy", rs1_busy, (rs1_addr != 0) && m_sb[rs1_addr] && !f1);
        chk("rs2_busy", rs2_busy, (rs2_addr != 0) && m_sb[rs2_addr] && !f2);
        chk("rf_write_en", rf_write_en, m_en);
        if (m_en) begin
            chk("rf_write_addr", rf_write_addr, m_addr);
            chk("rf_write_value", rf_write_value, m_val);
        end
        chk("rs1_fwd_valid", rs1_fwd_valid, f1);
        chk("rs2_fwd_valid", rs2_fwd_valid, f2);
        chk("rs1_fwd_data", rs1_fwd_data, f1 ? m_val : 32'h0);
        chk("rs2_fwd_data", rs2_fwd_data, f2 ? m_val : 32'h0);

        nw  = (lsu_valid && !gl) ? ((m_wait + 1 > MW) ? MW : m_wait + 1) : 0;
        nsb = m_sb;
        if (m_en && m_src_lsu) nsb[m_addr] = 1'b0;
        if (ld_issue_valid && ir && ld_issue_rd != 0) nsb[ld_issue_rd] = 1'b1;

        @(posedge clk);
        m_wait = nw;
        m_sb   = nsb;
        if (gl) begin
            m_en = (lsu_rd != 0); m_src_lsu = 1; m_addr = lsu_rd; m_val = lsu_data;
        end else if (gp) begin
            m_en = (pipe_rd != 0); m_src_lsu = 0; m_addr = pipe_rd; m_val = pipe_data;
        end else begin
            m_en = 0; m_src_lsu = 0;
        end
        last_gp = gp;
        last_gl = gl;
        #1;
    endtask

    initial begin
`ifdef REGFILE_ARB_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        reset = 1'b0;
        pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        ld_issue_valid = 0; ld_issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_en", rf_write_en, 1'b0);
        chk("reset_addr", rf_write_addr, 5'd0);
        chk("reset_value", rf_write_value, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Simultaneous requests: pipeline first, LSU next.
        pipe_valid = 1; pipe_rd = 5'd3; pipe_data = 32'hAA;
        lsu_valid = 1; lsu_rd = 5'd5; lsu_data = 32'h55;
        #1;
        chk("t2_pipe_ready", pipe_ready, 1'b1);
        chk("t2_lsu_wait", lsu_ready, 1'b0);
        step();
        chk("t2_en", rf_write_en, 1'b1);
        chk("t2_addr", rf_write_addr, 5'd3);
        chk("t2_value", rf_write_value, 32'hAA);
        pipe_valid = 0;
        #1;
        chk("t2_lsu_grant", lsu_ready, 1'b1);
        step();
        chk("t2_lsu_addr", rf_write_addr, 5'd5);
        lsu_valid = 0;

        // Starvation guard: LSU forced through on the fifth contended cycle.
        pipe_valid = 1; pipe_rd = 5'd10; pipe_data = 32'h100;
        lsu_valid = 1; lsu_rd = 5'd6; lsu_data = 32'h66;
        for (int i = 1; i <= 5; i++) begin
            #1;
            chk("t3_lsu_ready", lsu_ready, (i == 5));
            chk("t3_pipe_ready", pipe_ready, (i != 5));
            step();
        end
        lsu_data = 32'h67;
        #1;
        chk("t3_cnt_clr", lsu_ready, 1'b0);
        repeat (5) step();
        lsu_valid = 0;
        step();
        pipe_valid = 0;

        // Load scoreboard: set on issue, block reissue, clear two cycles after grant.
        rs1_addr = 5'd7; ld_issue_valid = 1; ld_issue_rd = 5'd7;
        #1;
        chk("t4_issue_ok", ld_issue_ready, 1'b1);
        chk("t4_not_busy", rs1_busy, 1'b0);
        step();
        #1;
        chk("t4_issue_blk", ld_issue_ready, 1'b0);
        chk("t4_busy", rs1_busy, 1'b1);
        ld_issue_valid = 0;
        lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'h77;
        #1;
        chk("t4_lsu_grant", lsu_ready, 1'b1);
        step();
        lsu_valid = 0;
        #1;
        chk("t4_busy_n1", rs1_busy, !bypass);
        chk("t4_fwd_n1", rs1_fwd_valid, bypass);
        step();
        chk("t4_busy_clr", rs1_busy, 1'b0);

        // Load to x0: handshake completes, no register-file write.
        lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'hFFFF;
        #1;
        chk("t5_lsu_ready", lsu_ready, 1'b1);
        step();
        chk("t5_no_write", rf_write_en, 1'b0);
        lsu_valid = 0;

        // Bypass of the in-flight write to a source that is marked busy.
        ld_issue_valid = 1; ld_issue_rd = 5'd9;
        step();
        ld_issue_valid = 0;
        pipe_valid = 1; pipe_rd = 5'd9; pipe_data = 32'h1234; rs2_addr = 5'd9;
        step();
        pipe_valid = 0;
        #1;
        chk("t6_fwd_valid", rs2_fwd_valid, bypass);
        chk("t6_fwd_data", rs2_fwd_data, bypass ? 32'h1234 : 32'h0);
        chk("t6_busy", rs2_busy, !bypass);

        // Random traffic respecting valid/ready holding rules.
        for (int c = 0; c < 1500; c++) begin
            if (!pipe_valid || last_gp) begin
                pipe_valid = ($urandom_range(0, 2) != 0);
                pipe_rd    = 5'($urandom_range(0, 31));
                pipe_data  = $urandom;
            end
            if (!lsu_valid || last_gl) begin
                lsu_valid = ($urandom_range(0, 1) != 0);
                lsu_rd    = ($urandom_range(0, 1) != 0) ? ld_issue_rd : 5'($urandom_range(0, 31));
                lsu_data  = $urandom;
            end
            ld_issue_valid = ($urandom_range(0, 3) == 0);
            ld_issue_rd    = 5'($urandom_range(0, 31));
            rs1_addr = ($urandom_range(0, 2) == 0) ? m_addr : 5'($urandom_range(0, 31));
            rs2_addr = ($urandom_range(0, 2) == 0) ? m_addr : 5'($urandom_range(0, 31));
            step();
        end

        // Drain outstanding requests legally.
        ld_issue_valid = 0;
        for (int c = 0; c < 20; c++) begin
            if (last_gp) pipe_valid = 0;
            if (last_gl) lsu_valid = 0;
            step();
        end
        chk("drain_idle", pipe_valid || lsu_valid, 1'b0);

        // Asynchronous reset in the middle of a write with a load pending.
        ld_issue_valid = 1; ld_issue_rd = 5'd12; rs1_addr = 5'd12; rs2_addr = 5'd12;
        if (m_sb[12]) begin
            lsu_valid = 1; lsu_rd = 5'd12; lsu_data = 32'hC;
            step();
            lsu_valid = 0;
            step();
        end
        step();
        ld_issue_valid = 0;
        pipe_valid = 1; pipe_rd = 5'd4; pipe_data = 32'h44;
        step();
        pipe_valid = 0;
        #1;
        chk("t1_pre_en", rf_write_en, 1'b1);
        chk("t1_pre_busy", rs1_busy, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk("t1_en", rf_write_en, 1'b0);
        chk("t1_addr", rf_write_addr, 5'd0);
        chk("t1_value", rf_write_value, 32'h0);
        chk("t1_rs1_busy", rs1_busy, 1'b0);
        chk("t1_rs2_busy", rs2_busy, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        ld_issue_valid = 1;
        repeat (3) step();
        ld_issue_valid = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
